// File: rtl/dmem_apb_sram_pkg.sv
// Shared types and constants for the APB data-memory completer.
// Holds the FSM encoding, wait-counter width and the legal write-strobe set.
package dmem_apb_sram_pkg;

   typedef enum logic {
      S_IDLE,
      S_ACCESS
   } dmem_state_e;

   localparam int WAIT_CNT_W = 4;

   // Byte, aligned half and full word are the only strobe shapes the LSU issues
   localparam int N_LEGAL_STRB = 7;
   localparam logic [N_LEGAL_STRB-1:0][3:0] LEGAL_STRB = {
      4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111
   };

   function automatic logic strb_legal(input logic [3:0] strb);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < N_LEGAL_STRB; i++) begin
         if (strb == LEGAL_STRB[i]) ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational decode of a latched APB request: range, alignment and strobe legality.
// Zero latency; no flow control of its own.
module dmem_access_check
   import dmem_apb_sram_pkg::*;
#(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic [31:0]                paddr,
   input  logic [3:0]                 pstrb,
   input  logic                       pwrite,
   output logic                       err,
   output logic [$clog2(DEPTH)-1:0]   idx
);

   localparam int          IDX_W = $clog2(DEPTH);
   localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

   logic [32:0] off;

   // 33-bit offset so an address below BASE_ADDR wraps to a huge value and fails the range test
   always_comb begin
      off = {1'b0, paddr} - {1'b0, BASE_ADDR};
      err = (off >= SPAN) || (paddr[1:0] != 2'b00) || (pwrite && !strb_legal(pstrb));
      idx = off[IDX_W+1:2];
   end

endmodule

// File: rtl/dmem_apb_sram.sv
// APB4 completer SRAM with byte-lane writes; pready after WAIT_STATES+1 access cycles.
// Stalls on penable=0 in the access phase and aborts cleanly if psel drops.
module dmem_apb_sram
   import dmem_apb_sram_pkg::*;
#(
   parameter int          DEPTH       = 256,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   input  logic [3:0]  pstrb,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        pslverr
);

   localparam int IDX_W = $clog2(DEPTH);

   dmem_state_e           state;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  pwrite_q;
   logic [31:0]           paddr_q;
   logic [31:0]           pwdata_q;
   logic [3:0]            pstrb_q;

   logic                  err;
   logic [IDX_W-1:0]      idx;
   logic                  done;
   logic [31:0]           mem [DEPTH];

   dmem_access_check #(
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE_ADDR)
   ) u_check (
      .paddr  (paddr_q),
      .pstrb  (pstrb_q),
      .pwrite (pwrite_q),
      .err    (err),
      .idx    (idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               // A request first seen with penable high still gets a full access phase
               if (psel) begin
                  pwrite_q <= pwrite;
                  paddr_q  <= paddr;
                  pwdata_q <= pwdata;
                  pstrb_q  <= pstrb;
                  wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
                  state    <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!psel) begin
                  state <= S_IDLE;
               end else if (penable) begin
                  if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                  else                state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Completion is decoded straight from state so an async reset drops the outputs at once
   assign done    = (state == S_ACCESS) && psel && penable && (wait_cnt == '0);
   assign pready  = done;
   assign pslverr = done && err;
   assign prdata  = (done && !pwrite_q && !err) ? mem[idx] : 32'h0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (done && pwrite_q && !err) begin
         for (int k = 0; k < 4; k++) begin
            if (pstrb_q[k]) mem[idx][8*k +: 8] <= pwdata_q[8*k +: 8];
         end
      end
   end

endmodule
